// File: rtl/demux_b.sv
// demux_b: registered 1-to-2 demultiplexer. Each accepted input word is steered
// by sel into one of two small FIFOs (channel 1 when sel=1, channel 2 when sel=0),
// each presenting its head word with a valid/ready handshake.
module demux_b #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out1_count,
    output logic [WIDTH-1:0]         out2_data,
    output logic                     out2_valid,
    input  logic                     out2_ready,
    output logic [$clog2(DEPTH):0]   out2_count
);

    localparam int AW = $clog2(DEPTH);   // index bits into storage
    localparam int PW = AW + 1;          // pointer bits, one extra to tell full from empty

    // Channel index 0 is output 1 (sel=1), index 1 is output 2 (sel=0).
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       cons_ready;
    logic [WIDTH-1:0] head  [2];
    logic [PW-1:0]    count [2];

    assign cons_ready = {out2_ready, out1_ready};

    // Ready only reflects the FIFO the current sel points at, so a stalled
    // channel never blocks traffic headed for the other one.
    assign in_ready = sel ? ~full[0] : ~full[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [WIDTH-1:0] mem_d [DEPTH];
            logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
            logic             chan_sel;

            assign chan_sel  = (gi == 0) ? sel : ~sel;
            assign empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign full[gi]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            // A full FIFO is never written, even if it pops on the same edge.
            assign push[gi]  = in_valid && chan_sel && ~full[gi];
            // An empty FIFO shows no valid, so a same-cycle push is not bypassed.
            assign pop[gi]   = ~empty[gi] && cons_ready[gi];

            assign head[gi]  = mem_q[rd_ptr_q[AW-1:0]];
            assign count[gi] = wr_ptr_q - rd_ptr_q;

            // Next-state for storage and pointers from this cycle's push/pop.
            always_comb begin
                mem_d    = mem_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push[gi]) begin
                    mem_d[wr_ptr_q[AW-1:0]] = in_data;
                    wr_ptr_d                = wr_ptr_q + PW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end

            // State register; reset flushes the channel and clears its storage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    mem_q    <= mem_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end
        end
    endgenerate

    assign out1_data  = head[0];
    assign out1_valid = ~empty[0];
    assign out1_count = count[0];
    assign out2_data  = head[1];
    assign out2_valid = ~empty[1];
    assign out2_count = count[1];

endmodule

// File: tb/tb_demux_b.sv
// tb_demux_b: directed stimulus for demux_b, checked every cycle against a
// queue-based model of the two channels plus literal expectations per scenario.
module tb_demux_b;

    localparam int WIDTH = 12;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [1:0]       out1_count;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [1:0]       out2_count;

    demux_b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_count (out1_count),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_count (out2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: one queue per channel; a channel accepts when it holds fewer than
    // DEPTH words, and pops only words that were already present before the edge.
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];

    always @(posedge clk) begin
        bit do_pop1, do_pop2, do_push1, do_push2;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            do_pop1  = (q1.size() > 0) && out1_ready;
            do_pop2  = (q2.size() > 0) && out2_ready;
            do_push1 = in_valid && sel  && (q1.size() < DEPTH);
            do_push2 = in_valid && !sel && (q2.size() < DEPTH);
            if (do_pop1) void'(q1.pop_front());
            if (do_pop2) void'(q2.pop_front());
            if (do_push1) q1.push_back(in_data);
            if (do_push2) q2.push_back(in_data);
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("m_out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
            check("m_out2_valid", 32'(out2_valid), 32'(q2.size() > 0));
            check("m_out1_count", 32'(out1_count), 32'(q1.size()));
            check("m_out2_count", 32'(out2_count), 32'(q2.size()));
            check("m_in_ready", 32'(in_ready),
                  32'(sel ? (q1.size() < DEPTH) : (q2.size() < DEPTH)));
            if (q1.size() > 0) check("m_out1_data", 32'(out1_data), 32'(q1[0]));
            if (q2.size() > 0) check("m_out2_data", 32'(out2_data), 32'(q2[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_drain [2];

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        sel        = 1'b0;
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        check_en = 1'b1;

        // Reset state
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out2_valid", 32'(out2_valid), 32'd0);
        check("rst_out1_count", 32'(out1_count), 32'd0);
        check("rst_out2_count", 32'(out2_count), 32'd0);
        check("rst_in_ready_sel0", 32'(in_ready), 32'd1);
        sel = 1'b1;
        #1;
        check("rst_in_ready_sel1", 32'(in_ready), 32'd1);

        // Single word to channel 1
        in_data  = 12'h0A5;
        sel      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_out1_valid", 32'(out1_valid), 32'd1);
        check("t1_out1_data", 32'(out1_data), 32'h0A5);
        check("t1_out1_count", 32'(out1_count), 32'd1);
        check("t1_out2_valid", 32'(out2_valid), 32'd0);
        check("t1_out2_count", 32'(out2_count), 32'd0);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        check("t1_drained", 32'(out1_count), 32'd0);

        // Fill channel 2, hold a third word until the consumer pops
        sel      = 1'b0;
        in_valid = 1'b1;
        in_data  = 12'h111;
        tick();
        in_data  = 12'h222;
        tick();
        check("t2_count_full", 32'(out2_count), 32'd2);
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        in_data = 12'h333;
        tick();
        check("t2_count_held", 32'(out2_count), 32'd2);
        check("t2_head_111", 32'(out2_data), 32'h111);
        out2_ready = 1'b1;
        tick();
        out2_ready = 1'b0;
        check("t2_count_after_pop", 32'(out2_count), 32'd1);
        check("t2_in_ready_reopen", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t2_count_refill", 32'(out2_count), 32'd2);
        exp_drain[0] = 12'h222;
        exp_drain[1] = 12'h333;
        out2_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t2_drain_%0d", i), 32'(out2_data), 32'(exp_drain[i]));
            tick();
        end
        out2_ready = 1'b0;
        check("t2_empty", 32'(out2_valid), 32'd0);

        // Channel 1 full does not block traffic to channel 2
        sel      = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'h001;
        tick();
        in_data  = 12'h002;
        tick();
        check("t3_out1_count", 32'(out1_count), 32'd2);
        check("t3_in_ready_sel1", 32'(in_ready), 32'd0);
        sel     = 1'b0;
        in_data = 12'hFFF;
        #1;
        check("t3_in_ready_sel0", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_out2_count", 32'(out2_count), 32'd1);
        check("t3_out2_data", 32'(out2_data), 32'hFFF);
        check("t3_out1_count_kept", 32'(out1_count), 32'd2);
        check("t3_out1_head", 32'(out1_data), 32'h001);
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        repeat (3) tick();
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        check("t3_out1_empty", 32'(out1_count), 32'd0);
        check("t3_out2_empty", 32'(out2_count), 32'd0);

        // Simultaneous push and pop on a partially filled channel
        sel      = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'h010;
        tick();
        check("t4_count_one", 32'(out1_count), 32'd1);
        in_data    = 12'h020;
        out1_ready = 1'b1;
        tick();
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        check("t4_count_same", 32'(out1_count), 32'd1);
        check("t4_head_020", 32'(out1_data), 32'h020);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;

        // Streaming alternating channels with both consumers ready
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data  = 12'(12'h100 + i);
            sel      = (i % 2 == 0);
            in_valid = 1'b1;
            tick();
            if (i % 2 == 0) begin
                check($sformatf("t5_ch1_valid_%0d", i), 32'(out1_valid), 32'd1);
                check($sformatf("t5_ch1_data_%0d", i), 32'(out1_data), 32'h100 + 32'(i));
            end else begin
                check($sformatf("t5_ch2_valid_%0d", i), 32'(out2_valid), 32'd1);
                check($sformatf("t5_ch2_data_%0d", i), 32'(out2_data), 32'h100 + 32'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        check("t5_ch1_empty", 32'(out1_valid), 32'd0);
        check("t5_ch2_empty", 32'(out2_valid), 32'd0);

        // Reset mid-operation flushes both channels and drops a concurrent push
        sel      = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'h0AA;
        tick();
        sel     = 1'b0;
        in_data = 12'h0BB;
        tick();
        check("t6_pre_count1", 32'(out1_count), 32'd1);
        check("t6_pre_count2", 32'(out2_count), 32'd1);
        sel     = 1'b1;
        in_data = 12'h0CC;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t6_out1_valid", 32'(out1_valid), 32'd0);
        check("t6_out2_valid", 32'(out2_valid), 32'd0);
        check("t6_out1_count", 32'(out1_count), 32'd0);
        check("t6_out2_count", 32'(out2_count), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("t6_not_retained", 32'(out1_valid), 32'd0);

        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
